// File: rtl/history_sequencer.sv
// history_sequencer: arbitrates save/undo/redo from two requesters, strobes the history
// buffer, replays restored pixels to the canvas and reports completion.
module history_sequencer #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [1:0] a_op,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [1:0] b_op,
  output logic       b_ready,
  input  logic [7:0] cur_x,
  input  logic [7:0] cur_y,
  input  logic [2:0] cur_color,
  output logic       hr_save,
  output logic       hr_undo,
  output logic       hr_redo,
  output logic [7:0] hr_x,
  output logic [7:0] hr_y,
  output logic [2:0] hr_color,
  input  logic [7:0] hr_x_out,
  input  logic [7:0] hr_y_out,
  input  logic [2:0] hr_color_out,
  input  logic       hr_restore_valid,
  input  logic       hr_can_undo,
  input  logic       hr_can_redo,
  output logic       px_valid,
  output logic [7:0] px_x,
  output logic [7:0] px_y,
  output logic [2:0] px_color,
  input  logic       px_ready,
  output logic       done,
  output logic       done_ok,
  output logic       done_id
);
  typedef enum logic [2:0] {IDLE, PULSE, GAP, WAIT, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d, acc_op;
  logic id_q, id_d, prio_b_q, prio_b_d, done_ok_q, done_ok_d, done_id_q, done_id_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] hr_x_q, hr_x_d, hr_y_q, hr_y_d, px_x_q, px_x_d, px_y_q, px_y_d;
  logic [2:0] hr_color_q, hr_color_d, px_color_q, px_color_d;
  logic idle, reject;
  assign idle = state_q == IDLE;
  // prio_b_q set means B wins the next tie
  assign a_ready = idle & a_valid & (~b_valid | ~prio_b_q);
  assign b_ready = idle & b_valid & (~a_valid | prio_b_q);
  assign acc_op = b_ready ? b_op : a_op;
  assign reject = acc_op == 2'b00 | (acc_op == 2'b10 & ~hr_can_undo) | (acc_op == 2'b11 & ~hr_can_redo);
  assign hr_save = state_q == PULSE & op_q == 2'b01;
  assign hr_undo = state_q == PULSE & op_q == 2'b10;
  assign hr_redo = state_q == PULSE & op_q == 2'b11;
  assign hr_x = hr_x_q;
  assign hr_y = hr_y_q;
  assign hr_color = hr_color_q;
  assign px_valid = state_q == WRITE;
  assign px_x = px_x_q;
  assign px_y = px_y_q;
  assign px_color = px_color_q;
  assign done = state_q == DONE;
  assign done_ok = done_ok_q;
  assign done_id = done_id_q;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    id_d = id_q;
    prio_b_d = prio_b_q;
    done_ok_d = done_ok_q;
    cnt_d = cnt_q;
    hr_x_d = hr_x_q;
    hr_y_d = hr_y_q;
    hr_color_d = hr_color_q;
    px_x_d = px_x_q;
    px_y_d = px_y_q;
    px_color_d = px_color_q;
    case (state_q)
      IDLE: if (a_ready | b_ready) begin
        op_d = acc_op;
        id_d = b_ready;
        prio_b_d = a_ready;
        hr_x_d = cur_x;
        hr_y_d = cur_y;
        hr_color_d = cur_color;
        state_d = reject ? DONE : PULSE;
        done_ok_d = reject ? 1'b0 : done_ok_q;
      end
      PULSE: begin
        state_d = op_q == 2'b01 ? GAP : WAIT;
        cnt_d = 4'd0;
      end
      GAP: begin
        state_d = DONE;
        done_ok_d = 1'b1;
      end
      WAIT: if (hr_restore_valid) begin
        px_x_d = hr_x_out;
        px_y_d = hr_y_out;
        px_color_d = hr_color_out;
        state_d = WRITE;
      end else begin
        cnt_d = cnt_q + 4'd1;
        state_d = cnt_d == 4'(TIMEOUT) ? DONE : WAIT;
        done_ok_d = cnt_d == 4'(TIMEOUT) ? 1'b0 : done_ok_q;
      end
      WRITE: begin
        state_d = px_ready ? DONE : WRITE;
        done_ok_d = px_ready ? 1'b1 : done_ok_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_id_d = state_d == DONE ? id_d : done_id_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= 2'b00;
      id_q <= 1'b0;
      prio_b_q <= 1'b0;
      done_ok_q <= 1'b0;
      done_id_q <= 1'b0;
      cnt_q <= 4'd0;
      hr_x_q <= 8'd0;
      hr_y_q <= 8'd0;
      hr_color_q <= 3'd0;
      px_x_q <= 8'd0;
      px_y_q <= 8'd0;
      px_color_q <= 3'd0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      id_q <= id_d;
      prio_b_q <= prio_b_d;
      done_ok_q <= done_ok_d;
      done_id_q <= done_id_d;
      cnt_q <= cnt_d;
      hr_x_q <= hr_x_d;
      hr_y_q <= hr_y_d;
      hr_color_q <= hr_color_d;
      px_x_q <= px_x_d;
      px_y_q <= px_y_d;
      px_color_q <= px_color_d;
    end
  end
endmodule

// File: tb/tb_history_sequencer.sv
// tb_history_sequencer: table-driven and randomized command checks against a spec-level model.
module tb_history_sequencer;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, a_ready, b_ready;
  logic [1:0] a_op = 2'd0, b_op = 2'd0;
  logic [7:0] cur_x = 8'd0, cur_y = 8'd0, hr_x, hr_y, hr_x_out = 8'd0, hr_y_out = 8'd0;
  logic [7:0] px_x, px_y;
  logic [2:0] cur_color = 3'd0, hr_color, hr_color_out = 3'd0, px_color;
  logic hr_save, hr_undo, hr_redo, hr_restore_valid = 1'b0, hr_can_undo = 1'b0, hr_can_redo = 1'b0;
  logic px_valid, px_ready = 1'b0, done, done_ok, done_id;
  int checks = 0, errors = 0;
  logic last_b = 1'b1;

  always #5 clk = ~clk;

  history_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_op(a_op), .a_ready(a_ready),
    .b_valid(b_valid), .b_op(b_op), .b_ready(b_ready),
    .cur_x(cur_x), .cur_y(cur_y), .cur_color(cur_color),
    .hr_save(hr_save), .hr_undo(hr_undo), .hr_redo(hr_redo),
    .hr_x(hr_x), .hr_y(hr_y), .hr_color(hr_color),
    .hr_x_out(hr_x_out), .hr_y_out(hr_y_out), .hr_color_out(hr_color_out),
    .hr_restore_valid(hr_restore_valid), .hr_can_undo(hr_can_undo), .hr_can_redo(hr_can_redo),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_color(px_color), .px_ready(px_ready),
    .done(done), .done_ok(done_ok), .done_id(done_id)
  );

  typedef struct {
    logic av; logic [1:0] aop; logic bv; logic [1:0] bop;
    logic cu; logic cr; logic rest; int pw;
    logic eid; logic eok; int elat; logic [1:0] estb;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  // Winner follows round-robin; outcome and latency come straight from the command rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic [1:0] op;
    r = v;
    r.eid = !v.av ? 1'b1 : !v.bv ? 1'b0 : !last_b;
    op = r.eid ? v.bop : v.aop;
    if (op == 2'd0 || (op == 2'd2 && !v.cu) || (op == 2'd3 && !v.cr)) begin
      r.estb = 2'd0; r.eok = 1'b0; r.elat = 1;
    end else if (op == 2'd1) begin
      r.estb = 2'd1; r.eok = 1'b1; r.elat = 3;
    end else begin
      r.estb = op; r.eok = v.rest; r.elat = v.rest ? 4 + v.pw : TO + 2;
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle; acts as both history buffer and canvas.
  task automatic do_cmd(input vec_t v);
    logic [7:0] x, y, rx, ry;
    logic [2:0] c, rc;
    logic [1:0] code, stb_seen;
    logic prev_stb, stb_err, snap_bad, rest_pending, px_seen, px_bad, done_seen, got_ok, got_id;
    int k, lat, pxw;
    x = 8'($urandom); y = 8'($urandom); c = 3'($urandom);
    rx = 8'($urandom); ry = 8'($urandom); rc = 3'($urandom);
    hr_x_out = rx; hr_y_out = ry; hr_color_out = rc;
    a_valid = v.av; a_op = v.aop; b_valid = v.bv; b_op = v.bop;
    cur_x = x; cur_y = y; cur_color = c; hr_can_undo = v.cu; hr_can_redo = v.cr;
    #1;
    chk("a_ready", 32'(a_ready), 32'(!v.eid));
    chk("b_ready", 32'(b_ready), 32'(v.eid));
    @(posedge clk); @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; a_op = ~a_op; b_op = ~b_op;
    cur_x = ~x; cur_y = ~y; cur_color = ~c; hr_can_undo = ~v.cu; hr_can_redo = ~v.cr;
    k = 1; lat = 0; pxw = 0; stb_seen = 2'd0; prev_stb = 1'b0; stb_err = 1'b0; snap_bad = 1'b0;
    rest_pending = 1'b0; px_seen = 1'b0; px_bad = 1'b0; done_seen = 1'b0; got_ok = 1'b0; got_id = 1'b0;
    while (!done_seen && k <= 40) begin
      code = hr_save ? 2'd1 : hr_undo ? 2'd2 : hr_redo ? 2'd3 : 2'd0;
      if ((32'(hr_save) + 32'(hr_undo) + 32'(hr_redo)) > 1 || (code != 2'd0 && prev_stb)) stb_err = 1'b1;
      if (code != 2'd0) begin
        stb_seen = code;
        if (hr_x !== x || hr_y !== y || hr_color !== c) snap_bad = 1'b1;
      end
      prev_stb = code != 2'd0;
      hr_restore_valid = rest_pending;
      rest_pending = code[1] && v.rest;
      if (px_valid) begin
        px_seen = 1'b1;
        if (px_x !== rx || px_y !== ry || px_color !== rc) px_bad = 1'b1;
        px_ready = pxw == v.pw;
        pxw++;
      end else px_ready = 1'b0;
      if (done) begin
        done_seen = 1'b1; lat = k; got_ok = done_ok; got_id = done_id;
      end else begin
        @(posedge clk); @(negedge clk);
        k++;
      end
    end
    hr_restore_valid = 1'b0; px_ready = 1'b0;
    chk("latency", 32'(lat), 32'(v.elat));
    chk("done_ok", 32'(got_ok), 32'(v.eok));
    chk("done_id", 32'(got_id), 32'(v.eid));
    chk("strobe_kind", 32'(stb_seen), 32'(v.estb));
    chk("strobe_spacing", 32'(stb_err), 32'd0);
    chk("hr_snapshot", 32'(snap_bad), 32'd0);
    chk("px_seen", 32'(px_seen), 32'(v.estb[1] && v.eok));
    chk("px_data", 32'(px_bad), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("done_ok_hold", 32'(done_ok), 32'(v.eok));
    chk("done_id_hold", 32'(done_id), 32'(v.eid));
    last_b = v.eid;
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{1'b1, 2'd1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 3, 2'd1};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1, 7, 2'd2};
    tbl[2]  = '{1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 3, 2'd1};
    tbl[3]  = '{1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 3, 2'd1};
    tbl[4]  = '{1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 3, 2'd1};
    tbl[5]  = '{1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 3, 2'd1};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1, 2'd0};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 6, 2'd3};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1, 2'd0};
    tbl[9]  = '{1'b1, 2'd3, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 3, 2'd1};
    tbl[10] = '{1'b1, 2'd3, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 4, 2'd3};
    tbl[11] = '{1'b0, 2'd0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1, 2'd0};
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobes", 32'({hr_save, hr_undo, hr_redo}), 32'd0);
    chk("rst_px_valid", 32'(px_valid), 32'd0);
    chk("rst_hr_x", 32'(hr_x), 32'd0);
    chk("rst_ready", 32'({a_ready, b_ready}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) do_cmd(tbl[i]);
    for (int i = 0; i < 60; i++) begin
      v.av = 1'($urandom); v.bv = 1'($urandom);
      if (!v.av && !v.bv) v.av = 1'b1;
      v.aop = 2'($urandom); v.bop = 2'($urandom);
      v.cu = 1'($urandom); v.cr = 1'($urandom);
      v.rest = $urandom_range(0, 3) != 0; v.pw = $urandom_range(0, 3);
      do_cmd(model(v));
    end
    // Abort an A undo while the pixel write is stalled; B would win the next tie without reset.
    a_valid = 1'b1; a_op = 2'd2; b_valid = 1'b0; hr_can_undo = 1'b1;
    hr_x_out = 8'h12; hr_y_out = 8'h34; hr_color_out = 3'd5;
    @(posedge clk); @(negedge clk);
    a_valid = 1'b0;
    chk("abort_hr_undo", 32'(hr_undo), 32'd1);
    @(negedge clk); hr_restore_valid = 1'b1;
    @(negedge clk); hr_restore_valid = 1'b0;
    chk("abort_px_valid", 32'(px_valid), 32'd1);
    chk("abort_px_x", 32'(px_x), 32'h12);
    repeat (2) @(negedge clk);
    chk("abort_px_hold", 32'(px_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_px_drop", 32'(px_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_px_x_clr", 32'(px_x), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    a_valid = 1'b1; a_op = 2'd1; b_valid = 1'b1; b_op = 2'd1;
    #1;
    chk("post_rst_tie", 32'({a_ready, b_ready}), 32'b10);
    @(posedge clk); @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    chk("mid_pulse_save", 32'(hr_save), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_pulse_drop", 32'(hr_save), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_done", 32'(done), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/history_sequencer.md
Name: history_sequencer

Overview:
- Front-end controller for the 8-entry undo/redo history buffer.
- Arbitrates save/undo/redo commands from two requesters: A = local button decoder, B = remote command port.
- Converts each accepted command into a correctly spaced strobe on the history buffer.
- On undo/redo, captures the restored {x, y, color} and replays it to the canvas as a single pixel write, then reports completion.

Parameters:
- TIMEOUT, 4: max cycles in WAIT for hr_restore_valid before failing the command (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- a_valid  in  1  requester A command valid
- a_op  in  2  A opcode: 01 save, 10 undo, 11 redo, 00 illegal
- a_ready  out  1  A command accepted this cycle (when a_valid high)
- b_valid  in  1  requester B command valid
- b_op  in  2  B opcode, same encoding as a_op
- b_ready  out  1  B command accepted this cycle
- cur_x  in  8  cursor x, snapshotted at accept
- cur_y  in  8  cursor y, snapshotted at accept
- cur_color  in  3  current color, snapshotted at accept
- hr_save  out  1  save strobe to history buffer
- hr_undo  out  1  undo strobe to history buffer
- hr_redo  out  1  redo strobe to history buffer
- hr_x  out  8  registered snapshot of cur_x
- hr_y  out  8  registered snapshot of cur_y
- hr_color  out  3  registered snapshot of cur_color
- hr_x_out  in  8  restored x from history buffer
- hr_y_out  in  8  restored y from history buffer
- hr_color_out  in  3  restored color from history buffer
- hr_restore_valid  in  1  one-cycle restore pulse from history buffer
- hr_can_undo  in  1  history buffer has an undoable entry
- hr_can_redo  in  1  history buffer has a redoable entry
- px_valid  out  1  canvas pixel write request
- px_x  out  8  pixel x
- px_y  out  8  pixel y
- px_color  out  3  pixel color
- px_ready  in  1  canvas accepts pixel write
- done  out  1  one-cycle command completion pulse
- done_ok  out  1  command succeeded; qualified by done
- done_id  out  1  requester of completed command: 0 = A, 1 = B; qualified by done

Behaviour:
- Reset values: every output 0; grant pointer favours A; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, PULSE, GAP, WAIT, WRITE, DONE.
- IDLE, arbitration:
  - a_ready/b_ready are combinational, high only in IDLE, for the arbitration winner only.
  - Single requester valid: it wins.
  - Both valid: round-robin; the requester not granted last wins. The first-ever tie goes to A.
- Accept = valid & ready. On accept, latch op, id, cur_x/y/color into hr_x/y/color, and update the grant pointer.
- Accept transitions:
  - op 00: go to DONE, done_ok = 0.
  - undo with hr_can_undo = 0: go to DONE, done_ok = 0, no strobe issued.
  - redo with hr_can_redo = 0: go to DONE, done_ok = 0, no strobe issued.
  - otherwise: go to PULSE.
- PULSE (exactly 1 cycle): the matching hr_* strobe is high; the other two are low.
  - save: go to GAP.
  - undo/redo: go to WAIT with the timeout counter cleared.
- GAP (1 cycle, strobes low): go to DONE, done_ok = 1.
- WAIT (strobes low):
  - hr_restore_valid = 1: latch hr_x_out/y_out/color_out into px_x/y/color, go to WRITE.
  - Otherwise increment the counter. When it reaches TIMEOUT, go to DONE with done_ok = 0.
  - Restore normally arrives in the first WAIT cycle.
- WRITE: px_valid = 1 with px_* held stable until px_ready = 1. On the handshake cycle go to DONE, done_ok = 1; px_valid drops the next cycle. No timeout in WRITE.
- DONE (1 cycle): done = 1, done_ok/done_id valid; next state IDLE.
  - done_ok/done_id hold their values until the next DONE.
  - done is 0 outside DONE.
- Strobe spacing: at least 1 cycle low between consecutive strobes. This is guaranteed because PULSE is always followed by a non-PULSE state, so the buffer's edge detectors always see a rising edge.
- Command latency, accept to done:
  - save: 3 cycles.
  - undo/redo: 4 + px_ready wait cycles.
- hr_restore_valid outside WAIT: ignored.
- px_ready outside WRITE: ignored.
- Requester op/cur_* changes after accept: no effect.
- rst asserted in any state: immediate return to reset values, including dropping px_valid and any strobe mid-cycle. No done is issued for the aborted command.

Test Plan:
- A save, cur = (0x12, 0x34, 5) → a_ready high 1 cycle; hr_save high 1 cycle with hr_x = 0x12, hr_y = 0x34, hr_color = 5; done = 1, done_ok = 1, done_id = 0 three cycles after accept.
- B undo, hr_can_undo = 1, model returns (0x12, 0x34, 5) → hr_undo pulse, px_valid with px_x = 0x12, px_y = 0x34, px_color = 5; px_ready delayed 3 cycles → px_* stable throughout, then done_ok = 1, done_id = 1.
- a_valid and b_valid held high with save ops for 4 commands → grants A, B, A, B; hr_save pulses separated by ≥1 low cycle.
- A undo with hr_can_undo = 0 → no hr_undo, no px_valid; done_ok = 0 one cycle after accept.
- Redo with hr_can_redo = 1 but hr_restore_valid never asserted, TIMEOUT = 4 → done_ok = 0 after 4 WAIT cycles; px_valid never asserted.
- rst pulsed while px_valid high awaiting px_ready → px_valid, done, and all strobes 0 immediately; the next request after reset is granted to A on a tie.
